// File: rtl/sequential_counter_pkg.sv
// Shared pin map, width limit and count-operation decode for the up/down counter user design.
package sequential_counter_pkg;

  localparam int unsigned IO_W        = 28;
  localparam int unsigned MAX_WIDTH   = 19;

  localparam int unsigned PIN_CLR     = 0;
  localparam int unsigned PIN_EN      = 1;
  localparam int unsigned PIN_DIR     = 2;
  localparam int unsigned PIN_LOAD    = 3;
  localparam int unsigned PIN_SAT     = 4;
  localparam int unsigned PIN_SDATA   = 5;
  localparam int unsigned PIN_SSTROBE = 6;
  localparam int unsigned PIN_CNT_LSB = 7;
  localparam int unsigned PIN_TC      = 26;
  localparam int unsigned PIN_WRAP    = 27;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } cnt_op_e;

  // Priority: clr over load over enabled counting.
  function automatic cnt_op_e decode_op(input logic clr, input logic load,
                                        input logic en, input logic dir);
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (en)   return dir ? OP_DOWN : OP_UP;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/serial_preset_shifter.sv
// Serial preset register: shifts sdata in MSB first on each sstrobe.
module serial_preset_shifter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdata,
  input  logic             sstrobe,
  output logic [WIDTH-1:0] shreg
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  if (WIDTH == 1) begin : g_w1
    always_comb shreg_d = sstrobe ? sdata : shreg_q;
  end else begin : g_wn
    always_comb shreg_d = sstrobe ? {shreg_q[WIDTH-2:0], sdata} : shreg_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shreg_q <= '0;
    else     shreg_q <= shreg_d;
  end

  assign shreg = shreg_q;

endmodule

// File: rtl/sequential_nbit_updown_counter.sv
// Parametrised up/down counter with saturate/wrap, serial preset, terminal count and sticky wrap flag.
module sequential_nbit_updown_counter
  import sequential_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned INIT  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("sequential_nbit_updown_counter: WIDTH must be 1..19");
  end

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = ~(CNT_MAX << 1);
  localparam logic [WIDTH-1:0] CNT_INIT = INIT[WIDTH-1:0];

  logic             clr, en, dir, load, sat, sdata, sstrobe;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             tc;
  cnt_op_e          op;
  logic             unused_io;

  assign clr       = io_in[PIN_CLR];
  assign en        = io_in[PIN_EN];
  assign dir       = io_in[PIN_DIR];
  assign load      = io_in[PIN_LOAD];
  assign sat       = io_in[PIN_SAT];
  assign sdata     = io_in[PIN_SDATA];
  assign sstrobe   = io_in[PIN_SSTROBE];
  assign unused_io = ^io_in[IO_W-1:PIN_CNT_LSB];

  serial_preset_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .sdata   (sdata),
    .sstrobe (sstrobe),
    .shreg   (shreg)
  );

  always_comb op = decode_op(clr, load, en, dir);

  // load takes the pre-shift shreg because shreg is a register output.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = wrap_q;
    unique case (op)
      OP_CLR: begin
        cnt_d  = CNT_INIT;
        wrap_d = 1'b0;
      end
      OP_LOAD: cnt_d = shreg;
      OP_UP: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (!sat) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end
      OP_DOWN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!sat) begin
          cnt_d  = CNT_MAX;
          wrap_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_INIT;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign tc = dir ? (cnt_q == '0) : (cnt_q == CNT_MAX);

  always_comb begin
    io_out                       = '0;
    io_out[PIN_CNT_LSB +: WIDTH] = cnt_q;
    io_out[PIN_TC]               = tc;
    io_out[PIN_WRAP]             = wrap_q;
  end

  always_comb begin
    io_oeb                       = '1;
    io_oeb[PIN_CNT_LSB +: WIDTH] = '0;
    io_oeb[PIN_TC]               = 1'b0;
    io_oeb[PIN_WRAP]             = 1'b0;
  end

endmodule
